sigma_np: RTL and testbench
===========================

SIGMA_NP -- requirements
Module: sigma_np

Interface
REQ-001 Parameter DW, default 8, sample width in bits.
REQ-002 Parameter LOG2N, default 4, window length N = 2**LOG2N samples (LOG2N >= 1).
REQ-003 Parameter SIGNED, default 0; 1 = data_in is two's complement, 0 = unsigned.
REQ-004 clk  in  1  single clock, rising edge active.
REQ-005 res  in  1  reset, asynchronous, active-low.
REQ-006 data_in  in  DW  sample.
REQ-007 in_vld  in  1  data_in is valid this cycle.
REQ-008 syn_in  in  1  window sync; a rising edge starts a window.
REQ-009 mode  in  1  0 = sum, 1 = average; sampled on the completing cycle.
REQ-010 data_out  out  DW+LOG2N  result, held until the next completion.
REQ-011 syn_out  out  1  one-cycle pulse, data_out updated.
REQ-012 busy  out  1  window in progress.
REQ-013 abort  out  1  one-cycle pulse, window restarted before completion.

Function
REQ-014 Edge detect: register syn_q <= syn_in; edge = syn_in & ~syn_q, evaluated at each rising clk.
REQ-015 States IDLE and ACC; busy = 1 exactly when the state is ACC.
REQ-016 IDLE, edge -> ACC with acc = 0 and cnt = 0; no sample is taken on the edge cycle.
REQ-017 ACC, in_vld = 1: acc += extended data_in (sign-extended if SIGNED, else zero-extended); cnt += 1.
REQ-018 ACC, in_vld = 0: acc and cnt hold; there is no timeout.
REQ-019 Completion occurs when cnt = N-1 and in_vld = 1; data_out <= final sum (mode 0) or final sum arithmetically shifted right by LOG2N and sign/zero-extended to DW+LOG2N (mode 1); syn_out <= 1 for one cycle; state -> IDLE.
REQ-020 Latency: with in_vld held at 1, syn_out is high in the cycle after clock edge e+N, where e is the edge-detect clock.
REQ-021 Accumulator width is DW+LOG2N; overflow is impossible; average rounds toward minus infinity.
REQ-022 Edge in ACC without completion: acc = 0, cnt = 0, stay in ACC, abort pulses one cycle, data_out unchanged.
REQ-023 Edge coinciding with completion: the completion is issued (data_out, syn_out); state remains ACC with acc and cnt cleared; no abort.
REQ-024 syn_in falling edges and level are ignored except through edge.

Reset
REQ-025 res low asynchronously forces IDLE, acc = 0, cnt = 0, syn_q = 0, data_out = 0, syn_out = 0, busy = 0, abort = 0.
REQ-026 Reset during a window discards it; no syn_out is produced; syn_in already high at release starts no window until it falls and rises again.

Structure
REQ-027 Package sigma_pkg holds the state enum {IDLE, ACC} and an output-width helper function (DW+LOG2N).
REQ-028 One sub-module, sigma_syn_edge (syn_q register plus rising-edge output), is instantiated for the edge detect; all other logic is in sigma_np.

Verification (defaults unless stated)
REQ-029 data_in = 1, in_vld = 1, mode = 0, single syn_in rise -> syn_out pulse once, 16 cycles after the edge clock; data_out = 12'h010; busy high for 16 cycles.
REQ-030 data_in = 8'hFF, mode = 0, then mode = 1 -> data_out = 12'hFF0, then 12'h0FF.
REQ-031 SIGNED = 1, data_in = 8'h80 -> mode 0 gives data_out = 12'h800; mode 1 gives 12'hF80.
REQ-032 in_vld alternating 1/0, data_in = 2 -> syn_out at the 16th accepted sample (about 32 cycles); data_out = 12'h020.
REQ-033 Second syn_in rise after 8 samples -> abort pulse, no syn_out at the old boundary; result 12'h010 after 16 new samples; a rise on the completion cycle -> syn_out, no abort, busy stays 1.
REQ-034 res asserted mid-window -> all outputs return to 0 immediately; no syn_out follows; N = 4 (LOG2N = 2) rerun gives data_out = 4 with syn_out after 4 samples.

Source files
------------

// File: rtl/sigma_pkg.sv
// sigma_pkg: shared types and helpers for the sigma_np windowed accumulator.
//   state_t    - window FSM state (IDLE, ACC)
//   out_width  - width of the accumulator and of the result bus (DW + LOG2N)
package sigma_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        ACC  = 1'b1
    } state_t;

    // A window of 2**log2n samples of dw bits each sums into dw+log2n bits
    // without overflow, signed or unsigned.
    function automatic int out_width(input int dw, input int log2n);
        return dw + log2n;
    endfunction

endpackage

// File: rtl/sigma_syn_edge.sv
// sigma_syn_edge: rising-edge detector for the window sync input.
//   clk      - clock, rising edge active
//   res      - asynchronous active-low reset
//   syn_in   - sync level input
//   syn_rise - high in the cycle where syn_in is high and was low on the
//              previous clock
// After reset the detector is disarmed until syn_in has been sampled low at
// least once, so a sync line that is already high when reset releases does
// not start a window; it has to fall and rise again.
module sigma_syn_edge (
    input  logic clk,
    input  logic res,
    input  logic syn_in,
    output logic syn_rise
);

    logic syn_q_reg;
    logic armed_reg;

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            syn_q_reg <= 1'b0;
            armed_reg <= 1'b0;
        end else begin
            syn_q_reg <= syn_in;
            armed_reg <= armed_reg | ~syn_in;
        end
    end

    assign syn_rise = syn_in & ~syn_q_reg & armed_reg;

endmodule

// File: rtl/sigma_np.sv
// sigma_np: sums (mode 0) or averages (mode 1) a window of N = 2**LOG2N
// valid samples, started by a rising edge of syn_in.
//   clk      - clock, rising edge active
//   res      - asynchronous active-low reset
//   data_in  - DW-bit sample, two's complement when SIGNED = 1
//   in_vld   - data_in valid this cycle
//   syn_in   - window sync; rising edge starts (or restarts) a window
//   mode     - 0 = sum, 1 = average (floor), sampled on the completing cycle
//   data_out - DW+LOG2N-bit result, held until the next completion
//   syn_out  - one-cycle pulse when data_out is updated
//   busy     - a window is in progress
//   abort    - one-cycle pulse when a window is restarted before completing
module sigma_np
    import sigma_pkg::*;
#(
    parameter int DW     = 8,
    parameter int LOG2N  = 4,
    parameter int SIGNED = 0,
    localparam int OW    = out_width(DW, LOG2N)
) (
    input  logic          clk,
    input  logic          res,
    input  logic [DW-1:0] data_in,
    input  logic          in_vld,
    input  logic          syn_in,
    input  logic          mode,
    output logic [OW-1:0] data_out,
    output logic          syn_out,
    output logic          busy,
    output logic          abort
);

    state_t           state_reg;
    logic [OW-1:0]    acc_reg;
    logic [LOG2N-1:0] cnt_reg;
    logic             syn_rise;
    logic [OW-1:0]    sample_ext;
    logic [OW-1:0]    sum_next;
    logic [OW-1:0]    avg_val;
    logic             complete;

    sigma_syn_edge u_syn_edge (
        .clk      (clk),
        .res      (res),
        .syn_in   (syn_in),
        .syn_rise (syn_rise)
    );

    // Extend the sample to accumulator width: replicate the sign bit for
    // two's complement input, zero-fill otherwise.
    assign sample_ext[DW-1:0] = data_in;
    for (genvar gi = 0; gi < LOG2N; gi++) begin : g_ext
        assign sample_ext[DW+gi] = (SIGNED != 0) ? data_in[DW-1] : 1'b0;
    end

    assign sum_next = acc_reg + sample_ext;

    // Arithmetic shift floors toward minus infinity for signed sums; the
    // shifted value is already sign/zero-extended to the full width.
    always_comb begin
        if (SIGNED != 0) begin
            avg_val = OW'($signed(sum_next) >>> LOG2N);
        end else begin
            avg_val = sum_next >> LOG2N;
        end
    end

    // cnt_reg all ones means N-1 samples already taken.
    assign complete = (state_reg == ACC) && in_vld && (&cnt_reg);

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state_reg <= IDLE;
            acc_reg   <= '0;
            cnt_reg   <= '0;
            data_out  <= '0;
            syn_out   <= 1'b0;
            abort     <= 1'b0;
        end else begin
            syn_out <= 1'b0;
            abort   <= 1'b0;
            if (state_reg == IDLE) begin
                // The edge cycle itself never contributes a sample.
                if (syn_rise) begin
                    state_reg <= ACC;
                    acc_reg   <= '0;
                    cnt_reg   <= '0;
                end
            end else begin
                if (complete) begin
                    data_out <= mode ? avg_val : sum_next;
                    syn_out  <= 1'b1;
                    acc_reg  <= '0;
                    cnt_reg  <= '0;
                    // A sync edge on the completing cycle opens the next
                    // window back-to-back instead of aborting.
                    if (!syn_rise) begin
                        state_reg <= IDLE;
                    end
                end else if (syn_rise) begin
                    acc_reg <= '0;
                    cnt_reg <= '0;
                    abort   <= 1'b1;
                end else if (in_vld) begin
                    acc_reg <= sum_next;
                    cnt_reg <= cnt_reg + LOG2N'(1);
                end
            end
        end
    end

    assign busy = (state_reg == ACC);

endmodule

// File: tb/tb_sigma_np.sv
// tb_sigma_np: bench for sigma_np. Three instances share one stimulus:
//   u_dut0 default (unsigned, N=16), u_dut1 SIGNED=1 (N=16),
//   u_dut2 LOG2N=2 (unsigned, N=4).
// A window-level model (list of accepted samples per window, summed and
// floor-divided on completion) is checked against all outputs every cycle;
// directed literal checks pin the model.
module tb_sigma_np;

    logic       clk = 1'b0;
    logic       res;
    logic [7:0] data_in = 8'h00;
    logic       in_vld = 1'b0;
    logic       syn_in = 1'b0;
    logic       mode = 1'b0;

    logic [11:0] dout0, dout1;
    logic [9:0]  dout2;
    logic        so0, so1, so2, bz0, bz1, bz2, ab0, ab1, ab2;

    sigma_np u_dut0 (
        .clk(clk), .res(res), .data_in(data_in), .in_vld(in_vld), .syn_in(syn_in), .mode(mode),
        .data_out(dout0), .syn_out(so0), .busy(bz0), .abort(ab0)
    );
    sigma_np #(.DW(8), .LOG2N(4), .SIGNED(1)) u_dut1 (
        .clk(clk), .res(res), .data_in(data_in), .in_vld(in_vld), .syn_in(syn_in), .mode(mode),
        .data_out(dout1), .syn_out(so1), .busy(bz1), .abort(ab1)
    );
    sigma_np #(.DW(8), .LOG2N(2), .SIGNED(0)) u_dut2 (
        .clk(clk), .res(res), .data_in(data_in), .in_vld(in_vld), .syn_in(syn_in), .mode(mode),
        .data_out(dout2), .syn_out(so2), .busy(bz2), .abort(ab2)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cycle = 0;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    localparam int MN [3] = '{16, 16, 4};
    localparam int MS [3] = '{0, 1, 0};
    localparam int MW [3] = '{12, 12, 10};

    int win   [3][16];
    int got   [3];
    bit act_m [3];
    int m_out [3];
    bit m_syn [3];
    bit m_ab  [3];
    bit prev_syn;
    bit seen_low;

    // event counters fed from observed outputs
    int syn_cnt  [3];
    int ab_cnt   [3];
    int busy_cnt [3];
    int last_out [3];
    int last_cyc [3];

    function automatic int sval(input int i, input logic [7:0] d);
        if (MS[i] != 0 && d[7]) return int'(d) - 256;
        return int'(d);
    endfunction

    function automatic int floor_div(input int s, input int n);
        if (s >= 0) return s / n;
        return -((-s + n - 1) / n);
    endfunction

    always @(posedge clk) begin
        bit e;
        int s;
        logic [31:0] a;
        int x;
        if (!res) begin
            for (int i = 0; i < 3; i++) begin
                got[i] = 0; act_m[i] = 0; m_out[i] = 0; m_syn[i] = 0; m_ab[i] = 0;
            end
            prev_syn = 0;
            seen_low = 0;
        end else begin
            e = syn_in && !prev_syn && seen_low;
            prev_syn = syn_in;
            if (!syn_in) seen_low = 1;
            for (int i = 0; i < 3; i++) begin
                m_syn[i] = 0;
                m_ab[i]  = 0;
                if (act_m[i]) begin
                    if (in_vld && got[i] == MN[i] - 1) begin
                        s = sval(i, data_in);
                        for (int k = 0; k < got[i]; k++) s += win[i][k];
                        if (mode) s = floor_div(s, MN[i]);
                        m_out[i] = s & ((1 << MW[i]) - 1);
                        m_syn[i] = 1;
                        got[i]   = 0;
                        act_m[i] = e;
                    end else if (e) begin
                        got[i]  = 0;
                        m_ab[i] = 1;
                    end else if (in_vld) begin
                        win[i][got[i]] = sval(i, data_in);
                        got[i]++;
                    end
                end else if (e) begin
                    act_m[i] = 1;
                    got[i]   = 0;
                end
            end
        end
        #1;
        for (int i = 0; i < 3; i++) begin
            case (i)
                0: a = 32'({dout0, so0, bz0, ab0});
                1: a = 32'({dout1, so1, bz1, ab1});
                default: a = 32'({2'b00, dout2, so2, bz2, ab2});
            endcase
            x = m_out[i] * 8 + int'(m_syn[i]) * 4 + int'(act_m[i]) * 2 + int'(m_ab[i]);
            check($sformatf("model_inst%0d_cyc%0d {dout,syn,busy,abort}", i, cycle), a, 32'(x));
            if (a[2]) begin
                syn_cnt[i]++;
                last_out[i] = int'(a[31:3]);
                last_cyc[i] = cycle;
            end
            if (a[0]) ab_cnt[i]++;
            if (a[1]) busy_cnt[i]++;
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic clr();
        for (int i = 0; i < 3; i++) begin
            syn_cnt[i] = 0; ab_cnt[i] = 0; busy_cnt[i] = 0; last_out[i] = -1; last_cyc[i] = 0;
        end
    endtask

    task automatic window(input logic [7:0] d, input bit m, input int n, input bit alt);
        @(negedge clk);
        mode = m; syn_in = 1'b1; in_vld = 1'b0;
        @(negedge clk);
        syn_in = 1'b0;
        for (int k = 0; k < n; k++) begin
            data_in = d; in_vld = 1'b1;
            @(negedge clk);
            if (alt) begin
                in_vld = 1'b0;
                @(negedge clk);
            end
        end
        in_vld = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int e;
        res = 1'b1;
        #1 res = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_dout0", 32'(dout0), 32'h0);
        check("reset_flags0", 32'({so0, bz0, ab0}), 32'h0);
        @(negedge clk) res = 1'b1;
        repeat (3) @(negedge clk);

        // unit samples, in_vld held high, latency and busy length
        clr();
        data_in = 8'd1; in_vld = 1'b1; mode = 1'b0; syn_in = 1'b1;
        @(posedge clk);
        #1 e = cycle;
        @(negedge clk) syn_in = 1'b0;
        repeat (20) @(negedge clk);
        in_vld = 1'b0;
        repeat (2) @(negedge clk);
        check("ones_syn_count", 32'(syn_cnt[0]), 32'd1);
        check("ones_latency", 32'(last_cyc[0] - e), 32'd16);
        check("ones_sum", 32'(last_out[0]), 32'h010);
        check("ones_busy_cycles", 32'(busy_cnt[0]), 32'd16);
        check("n4_sum", 32'(last_out[2]), 32'd4);
        check("n4_latency", 32'(last_cyc[2] - e), 32'd4);

        // full-scale samples, sum then average
        clr();
        window(8'hFF, 1'b0, 16, 1'b0);
        check("ff_sum_u", 32'(last_out[0]), 32'hFF0);
        check("ff_sum_s", 32'(last_out[1]), 32'hFF0);
        window(8'hFF, 1'b1, 16, 1'b0);
        check("ff_avg_u", 32'(last_out[0]), 32'h0FF);
        check("ff_avg_s", 32'(last_out[1]), 32'hFFF);

        // most negative signed sample
        window(8'h80, 1'b0, 16, 1'b0);
        check("m128_sum_s", 32'(last_out[1]), 32'h800);
        window(8'h80, 1'b1, 16, 1'b0);
        check("m128_avg_s", 32'(last_out[1]), 32'hF80);
        check("x80_avg_u", 32'(last_out[0]), 32'h080);

        // alternating valid
        clr();
        window(8'd2, 1'b0, 16, 1'b1);
        check("alt_sum", 32'(last_out[0]), 32'h020);
        check("alt_syn_count", 32'(syn_cnt[0]), 32'd1);

        // restart after 8 samples
        clr();
        window(8'd1, 1'b0, 8, 1'b0);
        check("part_no_syn", 32'(syn_cnt[0]), 32'd0);
        check("part_still_busy", 32'(bz0), 32'd1);
        window(8'd1, 1'b0, 16, 1'b0);
        check("restart_abort_count", 32'(ab_cnt[0]), 32'd1);
        check("restart_syn_count", 32'(syn_cnt[0]), 32'd1);
        check("restart_sum", 32'(last_out[0]), 32'h010);
        check("restart_n4_no_abort", 32'(ab_cnt[2]), 32'd0);

        // edge on the completing cycle
        clr();
        @(negedge clk) syn_in = 1'b1; mode = 1'b0;
        @(negedge clk) syn_in = 1'b0; data_in = 8'd1; in_vld = 1'b1;
        repeat (15) @(negedge clk);
        syn_in = 1'b1;
        @(posedge clk);
        #1;
        check("coinc_syn_out", 32'(so0), 32'd1);
        check("coinc_no_abort", 32'(ab0), 32'd0);
        check("coinc_busy", 32'(bz0), 32'd1);
        @(negedge clk) syn_in = 1'b0;
        repeat (16) @(negedge clk);
        in_vld = 1'b0;
        repeat (2) @(negedge clk);
        check("coinc_syn_count", 32'(syn_cnt[0]), 32'd2);
        check("coinc_abort_count", 32'(ab_cnt[0]), 32'd0);
        check("coinc_second_sum", 32'(last_out[0]), 32'h010);

        // reset mid-window with syn_in high across release
        @(negedge clk) syn_in = 1'b1;
        @(negedge clk) syn_in = 1'b0; data_in = 8'd1; in_vld = 1'b1;
        repeat (5) @(negedge clk);
        syn_in = 1'b1;
        res = 1'b0;
        #1;
        check("rst_mid_dout0", 32'(dout0), 32'h0);
        check("rst_mid_flags0", 32'({so0, bz0, ab0}), 32'h0);
        check("rst_mid_dout2", 32'(dout2), 32'h0);
        repeat (3) @(negedge clk);
        res = 1'b1;
        clr();
        repeat (20) @(negedge clk);
        check("rst_high_no_syn", 32'(syn_cnt[0] + syn_cnt[2]), 32'd0);
        check("rst_high_no_busy", 32'(busy_cnt[0] + busy_cnt[2]), 32'd0);
        syn_in = 1'b0; in_vld = 1'b0;
        @(negedge clk);
        window(8'd1, 1'b0, 4, 1'b0);
        check("rst_n4_sum", 32'(last_out[2]), 32'd4);
        check("rst_n4_syn_count", 32'(syn_cnt[2]), 32'd1);
        check("rst_n16_no_syn", 32'(syn_cnt[0]), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
